mem_subword_rmw: RTL and testbench

- Sequential successor to the byte/half/word store-merge mux in the datapath. Sits between the core's load/store stage and a word-wide synchronous memory.
- Accepts one load or store request at a time. Sub-word stores are performed as read-modify-write: read the word, merge the lane, write it back.
- Loads are lane-extracted and sign- or zero-extended.
- Generalised in data width and memory read latency. Adds a handshake, lane selection by address offset, and misalignment detection.

---
 rtl/mem_subword_rmw_pkg.sv | 25 ++
 rtl/mem_subword_rmw_if.sv | 31 +++
 rtl/mem_subword_rmw_lane.sv | 44 ++++
 rtl/mem_subword_rmw.sv | 129 ++++++++++++
 tb/tb_mem_subword_rmw.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_subword_rmw_pkg.sv
// rtl/mem_subword_rmw_pkg.sv - shared size/state encodings and lane-offset width helper
package mem_subword_pkg;

  typedef enum logic [1:0] {
    SZ_WORD = 2'b00,
    SZ_HALF = 2'b01,
    SZ_BYTE = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WAIT = 3'd2,
    ST_WR   = 3'd3,
    ST_RESP = 3'd4,
    ST_ERR  = 3'd5
  } state_e;

  // Number of byte-offset bits within one memory word.
  function automatic int lane_off_w(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/mem_subword_rmw_if.sv
// rtl/mem_subword_rmw_if.sv - request/response and memory-side bus bundle
interface mem_subword_rmw_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_err;
  logic [DATA_W-1:0] resp_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic              mem_wr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_err, resp_rdata, mem_addr, mem_rd, mem_wr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_err, resp_rdata, mem_addr, mem_rd, mem_wr, mem_wdata
  );
endinterface

// File: rtl/mem_subword_rmw_lane.sv
// rtl/mem_subword_rmw_lane.sv - combinational little-endian lane merge and sign/zero extract
module subword_lane_unit
  import mem_subword_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OFF_W  = lane_off_w(DATA_W)
) (
  input  logic [DATA_W-1:0] word_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [OFF_W-1:0]  off_i,
  input  size_e             size_i,
  input  logic              signed_i,
  output logic [DATA_W-1:0] merged_o,
  output logic [DATA_W-1:0] extended_o
);
  logic [OFF_W+2:0] byte_pos;
  logic [OFF_W+2:0] half_pos;
  logic [7:0]       lane_b;
  logic [15:0]      lane_h;

  // Half position ignores off[0] so the slice never runs past the word.
  assign byte_pos = {off_i, 3'b000};
  assign half_pos = {off_i[OFF_W-1:1], 4'b0000};
  assign lane_b   = word_i[byte_pos +: 8];
  assign lane_h   = word_i[half_pos +: 16];

  always_comb begin
    merged_o = word_i;
    case (size_i)
      SZ_BYTE: merged_o[byte_pos +: 8]  = wdata_i[7:0];
      SZ_HALF: merged_o[half_pos +: 16] = wdata_i[15:0];
      default: merged_o = wdata_i;
    endcase
  end

  always_comb begin
    extended_o = word_i;
    case (size_i)
      SZ_BYTE: extended_o = {{(DATA_W-8){signed_i & lane_b[7]}}, lane_b};
      SZ_HALF: extended_o = {{(DATA_W-16){signed_i & lane_h[15]}}, lane_h};
      default: extended_o = word_i;
    endcase
  end
endmodule

// File: rtl/mem_subword_rmw.sv
// rtl/mem_subword_rmw.sv - single-outstanding load/store unit with sub-word read-modify-write; MISALIGN_TRAP_EN enables error trapping
module mem_subword_rmw
  import mem_subword_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int MEM_LAT = 1
) (
  input logic           clk,
  input logic           reset,
  mem_subword_rmw_if.slave bus
);
  localparam int         OFF_W = lane_off_w(DATA_W);
  localparam logic [2:0] IDLE  = 3'(ST_IDLE);
  localparam logic [2:0] RD    = 3'(ST_RD);
  localparam logic [2:0] WAIT  = 3'(ST_WAIT);
  localparam logic [2:0] WR    = 3'(ST_WR);
  localparam logic [2:0] RESP  = 3'(ST_RESP);
  localparam logic [2:0] ERR   = 3'(ST_ERR);
  localparam logic [2:0] LAST  = 3'(MEM_LAT - 1);

  logic [2:0]              state_q, state_d;
  logic [2:0]              cnt_q, cnt_d;
  logic [DATA_W-1:0]       word_q, word_d;
  logic [ADDR_W-OFF_W-1:0] waddr_q;
  logic [OFF_W-1:0]        off_q;
  size_e                   size_q;
  logic                    we_q, sgn_q;
  logic [DATA_W-1:0]       wdata_q;

  logic             accept, bad_in;
  logic [OFF_W-1:0] off_in, off_acc;
  size_e            size_in, size_acc;
  logic [DATA_W-1:0] merged, extended;

  assign accept  = bus.req_valid && (state_q == IDLE);
  assign off_in  = bus.req_addr[OFF_W-1:0];
  assign size_in = size_e'(bus.req_size);

  always_comb begin
    bad_in   = 1'b0;
    size_acc = size_in;
    off_acc  = off_in;
`ifdef MISALIGN_TRAP_EN
    bad_in = (size_in == SZ_RSVD) || (size_in == SZ_HALF && off_in[0]) ||
             (size_in == SZ_WORD && off_in != '0);
`else
    // Without trapping, offset bits finer than the access size are dropped.
    if (size_in == SZ_RSVD) size_acc = SZ_WORD;
    if (size_acc == SZ_WORD) off_acc = '0;
    else if (size_acc == SZ_HALF) off_acc = {off_in[OFF_W-1:1], 1'b0};
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    case (state_q)
      IDLE: if (accept) begin
        if (bad_in) state_d = ERR;
        else if (bus.req_we && size_acc == SZ_WORD) state_d = WR;
        else state_d = RD;
      end
      RD: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: if (cnt_q == LAST) begin
        word_d  = bus.mem_rdata;
        state_d = we_q ? WR : RESP;
      end else begin
        cnt_d = cnt_q + 3'd1;
      end
      WR:      state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      word_q  <= '0;
      waddr_q <= '0;
      off_q   <= '0;
      size_q  <= SZ_WORD;
      we_q    <= 1'b0;
      sgn_q   <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      if (accept) begin
        waddr_q <= bus.req_addr[ADDR_W-1:OFF_W];
        off_q   <= off_acc;
        size_q  <= size_acc;
        we_q    <= bus.req_we;
        sgn_q   <= bus.req_signed;
        wdata_q <= bus.req_wdata;
      end
    end
  end

  subword_lane_unit #(.DATA_W(DATA_W), .OFF_W(OFF_W)) u_lane (
    .word_i     (word_q),
    .wdata_i    (wdata_q),
    .off_i      (off_q),
    .size_i     (size_q),
    .signed_i   (sgn_q),
    .merged_o   (merged),
    .extended_o (extended)
  );

  // Outputs decode straight from state so reset removes strobes immediately.
  assign bus.req_ready  = (state_q == IDLE);
  assign bus.mem_rd     = (state_q == RD);
  assign bus.mem_wr     = (state_q == WR);
  assign bus.mem_addr   = {waddr_q, {OFF_W{1'b0}}};
  assign bus.mem_wdata  = (state_q == WR) ? merged : '0;
  assign bus.resp_valid = (state_q == RESP) || (state_q == ERR);
  assign bus.resp_rdata = (state_q == RESP && !we_q) ? extended : '0;
`ifdef MISALIGN_TRAP_EN
  assign bus.resp_err   = (state_q == ERR);
`else
  assign bus.resp_err   = 1'b0;
`endif
endmodule

// File: tb/tb_mem_subword_rmw.sv
// tb/tb_mem_subword_rmw.sv - directed bench for 32-bit/lat-1 and 64-bit/lat-3 instances
module tb_mem_subword_rmw;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  mem_subword_rmw_if #(.DATA_W(32), .ADDR_W(32)) ifa ();
  mem_subword_rmw_if #(.DATA_W(64), .ADDR_W(32)) ifb ();

  mem_subword_rmw #(.DATA_W(32), .ADDR_W(32), .MEM_LAT(1)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
  mem_subword_rmw #(.DATA_W(64), .ADDR_W(32), .MEM_LAT(3)) dut_b (.clk(clk), .reset(reset), .bus(ifb));

  // Memory models: read data is only valid exactly MEM_LAT cycles after mem_rd.
  logic [31:0] mem_a [16];
  logic [63:0] mem_b [16];
  logic        pl_en = 1'b0, pl_sel = 1'b0;
  logic [3:0]  pl_idx = '0;
  logic [63:0] pl_val = '0;
  logic        a_v = 1'b0;
  logic [31:0] a_d = '0;
  logic [2:0]  b_v = '0;
  logic [63:0] b_d0 = '0, b_d1 = '0, b_d2 = '0;
  int          a_wr_total = 0;
  int          both_hi = 0;

  always @(posedge clk) begin
    if (pl_en && !pl_sel) mem_a[pl_idx] <= pl_val[31:0];
    else if (ifa.mem_wr) mem_a[ifa.mem_addr[5:2]] <= ifa.mem_wdata;
    if (pl_en && pl_sel) mem_b[pl_idx] <= pl_val;
    else if (ifb.mem_wr) mem_b[ifb.mem_addr[6:3]] <= ifb.mem_wdata;
    a_v  <= ifa.mem_rd;
    a_d  <= mem_a[ifa.mem_addr[5:2]];
    b_v  <= {b_v[1:0], ifb.mem_rd};
    b_d0 <= mem_b[ifb.mem_addr[6:3]];
    b_d1 <= b_d0;
    b_d2 <= b_d1;
    if (ifa.mem_wr) a_wr_total <= a_wr_total + 1;
    if ((ifa.mem_rd && ifa.mem_wr) || (ifb.mem_rd && ifb.mem_wr)) both_hi <= both_hi + 1;
  end
  assign ifa.mem_rdata = a_v    ? a_d  : 32'hDEAD_BEEF;
  assign ifb.mem_rdata = b_v[2] ? b_d2 : 64'hDEAD_BEEF_DEAD_BEEF;

  // Results of the last run_req.
  int          r_resp, r_wr, r_rd_n, r_wr_n;
  logic        r_err, r_rdy0;
  logic [63:0] r_rdata, r_wseen;

  task automatic preload(input logic sel, input logic [3:0] idx, input logic [63:0] val);
    @(negedge clk);
    pl_sel = sel; pl_idx = idx; pl_val = val; pl_en = 1'b1;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic drive(input logic sel, input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [63:0] wdata);
    if (sel) begin
      ifb.req_we = we; ifb.req_size = size; ifb.req_signed = sgn;
      ifb.req_addr = addr; ifb.req_wdata = wdata; ifb.req_valid = 1'b1;
    end else begin
      ifa.req_we = we; ifa.req_size = size; ifa.req_signed = sgn;
      ifa.req_addr = addr; ifa.req_wdata = wdata[31:0]; ifa.req_valid = 1'b1;
    end
  endtask

  // Cycle 0 is the accept cycle; outputs sampled on the falling edge of each later cycle.
  task automatic run_req(input logic sel, input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [63:0] wdata);
    r_resp = -1; r_wr = -1; r_rd_n = 0; r_wr_n = 0; r_err = 1'b0; r_rdata = '0; r_wseen = '0;
    @(negedge clk);
    r_rdy0 = sel ? ifb.req_ready : ifa.req_ready;
    drive(sel, we, size, sgn, addr, wdata);
    @(posedge clk);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) begin ifa.req_valid = 1'b0; ifb.req_valid = 1'b0; end
      if (sel ? ifb.mem_rd : ifa.mem_rd) r_rd_n++;
      if (sel ? ifb.mem_wr : ifa.mem_wr) begin
        r_wr_n++; r_wr = c;
        r_wseen = sel ? ifb.mem_wdata : {32'h0, ifa.mem_wdata};
      end
      if (sel ? ifb.resp_valid : ifa.resp_valid) begin
        r_resp = c;
        r_err = sel ? ifb.resp_err : ifa.resp_err;
        r_rdata = sel ? ifb.resp_rdata : {32'h0, ifa.resp_rdata};
        break;
      end
    end
  endtask

  task automatic test_reset();
    total++;
    if ({ifa.req_ready, ifa.resp_valid, ifa.resp_err, ifa.mem_rd, ifa.mem_wr} !== 5'b10000) begin
      bad++; $display("FAIL reset_ctl_a: got %b want 10000",
                      {ifa.req_ready, ifa.resp_valid, ifa.resp_err, ifa.mem_rd, ifa.mem_wr});
    end
    total++;
    if ({ifa.resp_rdata, ifa.mem_addr, ifa.mem_wdata} !== 96'h0) begin
      bad++; $display("FAIL reset_data_a: got %h/%h/%h want 0", ifa.resp_rdata, ifa.mem_addr, ifa.mem_wdata);
    end
    total++;
    if ({ifb.req_ready, ifb.resp_valid, ifb.mem_rd, ifb.mem_wr} !== 4'b1000) begin
      bad++; $display("FAIL reset_ctl_b: got %b want 1000",
                      {ifb.req_ready, ifb.resp_valid, ifb.mem_rd, ifb.mem_wr});
    end
  endtask

  task automatic test_load_byte();
    run_req(1'b0, 1'b0, 2'b10, 1'b1, 32'h12, 64'h0);
    total++; if (r_resp !== 3) begin bad++; $display("FAIL ldb_s_lat: got %0d want 3", r_resp); end
    total++; if (r_rdata !== 64'hFFFF_FFBB) begin bad++; $display("FAIL ldb_s_data: got %h want ffffffbb", r_rdata); end
    total++; if (r_rd_n !== 1 || r_wr_n !== 0) begin bad++; $display("FAIL ldb_strobes: got rd=%0d wr=%0d want 1/0", r_rd_n, r_wr_n); end
    total++; if (r_rdy0 !== 1'b1) begin bad++; $display("FAIL ldb_ready: got %b want 1", r_rdy0); end
    run_req(1'b0, 1'b0, 2'b10, 1'b0, 32'h12, 64'h0);
    total++; if (r_rdata !== 64'h0000_00BB) begin bad++; $display("FAIL ldb_u_data: got %h want 000000bb", r_rdata); end
    run_req(1'b0, 1'b0, 2'b10, 1'b1, 32'h11, 64'h0);
    total++; if (r_rdata !== 64'hFFFF_FFCC) begin bad++; $display("FAIL ldb_off1: got %h want ffffffcc", r_rdata); end
    run_req(1'b0, 1'b0, 2'b01, 1'b1, 32'h12, 64'h0);
    total++; if (r_rdata !== 64'hFFFF_AABB) begin bad++; $display("FAIL ldh_s: got %h want ffffaabb", r_rdata); end
    run_req(1'b0, 1'b0, 2'b00, 1'b1, 32'h10, 64'h0);
    total++; if (r_rdata !== 64'hAABB_CCDD) begin bad++; $display("FAIL ldw: got %h want aabbccdd", r_rdata); end
  endtask

  task automatic test_store_half();
    run_req(1'b0, 1'b1, 2'b01, 1'b0, 32'h12, 64'hFFFF_1234);
    total++; if (r_rd_n !== 1) begin bad++; $display("FAIL sth_rd: got %0d want 1", r_rd_n); end
    total++; if (r_wr !== 3) begin bad++; $display("FAIL sth_wr_cyc: got %0d want 3", r_wr); end
    total++; if (r_wseen !== 64'h1234_CCDD) begin bad++; $display("FAIL sth_wdata: got %h want 1234ccdd", r_wseen); end
    total++; if (r_resp !== 4) begin bad++; $display("FAIL sth_lat: got %0d want 4", r_resp); end
    total++; if (r_rdata !== 64'h0 || r_err !== 1'b0) begin bad++; $display("FAIL sth_resp: got %h err=%b want 0", r_rdata, r_err); end
    run_req(1'b0, 1'b0, 2'b00, 1'b0, 32'h10, 64'h0);
    total++; if (r_rdata !== 64'h1234_CCDD) begin bad++; $display("FAIL sth_readback: got %h want 1234ccdd", r_rdata); end
  endtask

  task automatic test_store_word();
    run_req(1'b0, 1'b1, 2'b00, 1'b0, 32'h20, 64'hCAFE_F00D);
    total++; if (r_wr !== 1 || r_rd_n !== 0) begin bad++; $display("FAIL stw_strobes: got wr_cyc=%0d rd=%0d want 1/0", r_wr, r_rd_n); end
    total++; if (r_resp !== 2) begin bad++; $display("FAIL stw_lat: got %0d want 2", r_resp); end
    total++; if (mem_a[8] !== 32'hCAFE_F00D) begin bad++; $display("FAIL stw_mem: got %h want cafef00d", mem_a[8]); end
  endtask

  task automatic test_misalign();
    run_req(1'b0, 1'b0, 2'b01, 1'b0, 32'h13, 64'h0);
`ifdef MISALIGN_TRAP_EN
    total++; if (r_resp !== 1 || r_err !== 1'b1) begin bad++; $display("FAIL mis_half: got cyc=%0d err=%b want 1/1", r_resp, r_err); end
    total++; if (r_rd_n !== 0 || r_wr_n !== 0 || r_rdata !== 64'h0) begin bad++; $display("FAIL mis_half_quiet: got rd=%0d wr=%0d data=%h want 0", r_rd_n, r_wr_n, r_rdata); end
    run_req(1'b0, 1'b0, 2'b11, 1'b0, 32'h10, 64'h0);
    total++; if (r_resp !== 1 || r_err !== 1'b1) begin bad++; $display("FAIL mis_rsvd: got cyc=%0d err=%b want 1/1", r_resp, r_err); end
`else
    total++; if (r_resp !== 3 || r_err !== 1'b0) begin bad++; $display("FAIL mis_half: got cyc=%0d err=%b want 3/0", r_resp, r_err); end
    total++; if (r_rdata !== 64'h0000_1234) begin bad++; $display("FAIL mis_half_data: got %h want 00001234", r_rdata); end
    run_req(1'b0, 1'b0, 2'b11, 1'b0, 32'h10, 64'h0);
    total++; if (r_rdata !== 64'h1234_CCDD || r_err !== 1'b0) begin bad++; $display("FAIL mis_rsvd: got %h err=%b want 1234ccdd/0", r_rdata, r_err); end
`endif
  endtask

  task automatic test_back_to_back();
    int first_rdy, resp1, resp2, wr1, rd_n;
    logic [63:0] wseen;
    first_rdy = -1; resp1 = -1; resp2 = -1; wr1 = -1; rd_n = 0; wseen = '0;
    @(negedge clk);
    drive(1'b1, 1'b1, 2'b10, 1'b0, 32'h17, 64'hFFFF_FFFF_FFFF_FF5A);
    @(posedge clk);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 8) ifb.req_valid = 1'b0;
      if (ifb.mem_rd) rd_n++;
      if (ifb.req_ready && first_rdy < 0) first_rdy = c;
      if (ifb.mem_wr && wr1 < 0) begin wr1 = c; wseen = ifb.mem_wdata; end
      if (ifb.resp_valid) begin
        if (resp1 < 0) resp1 = c;
        else begin resp2 = c; break; end
      end
    end
    ifb.req_valid = 1'b0;
    total++; if (wseen !== 64'h5A22_3344_5566_7788) begin bad++; $display("FAIL b_stb_wdata: got %h want 5a22334455667788", wseen); end
    total++; if (wr1 !== 5) begin bad++; $display("FAIL b_stb_wr_cyc: got %0d want 5", wr1); end
    total++; if (resp1 !== 6) begin bad++; $display("FAIL b_stb_lat: got %0d want 6", resp1); end
    total++; if (first_rdy !== 7) begin bad++; $display("FAIL b_ready_return: got %0d want 7", first_rdy); end
    total++; if (resp2 !== 13 || rd_n !== 2) begin bad++; $display("FAIL b_second: got cyc=%0d rd=%0d want 13/2", resp2, rd_n); end
  endtask

  task automatic test_wide_load();
    run_req(1'b1, 1'b0, 2'b10, 1'b1, 32'h10, 64'h0);
    total++; if (r_resp !== 5) begin bad++; $display("FAIL b_ld_lat: got %0d want 5", r_resp); end
    total++; if (r_rdata !== 64'hFFFF_FFFF_FFFF_FF88) begin bad++; $display("FAIL b_ldb_s: got %h want ffffffffffffff88", r_rdata); end
    run_req(1'b1, 1'b0, 2'b01, 1'b0, 32'h16, 64'h0);
    total++; if (r_rdata !== 64'h5A22) begin bad++; $display("FAIL b_ldh_u: got %h want 5a22", r_rdata); end
  endtask

  task automatic test_reset_abort();
    int wr_snap;
    @(negedge clk);
    drive(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 64'h77);
    @(posedge clk);
    @(negedge clk);
    ifa.req_valid = 1'b0;
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    wr_snap = a_wr_total;
    total++;
    if ({ifa.req_ready, ifa.resp_valid, ifa.mem_rd, ifa.mem_wr} !== 4'b1000) begin
      bad++; $display("FAIL abort_ctl: got %b want 1000", {ifa.req_ready, ifa.resp_valid, ifa.mem_rd, ifa.mem_wr});
    end
    total++;
    if ({ifa.resp_rdata, ifa.mem_addr, ifa.mem_wdata} !== 96'h0) begin
      bad++; $display("FAIL abort_data: got %h/%h/%h want 0", ifa.resp_rdata, ifa.mem_addr, ifa.mem_wdata);
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    total++; if (a_wr_total !== wr_snap || mem_a[4] !== 32'h1234_CCDD) begin bad++; $display("FAIL abort_no_write: got wr=%0d mem=%h want %0d/1234ccdd", a_wr_total, mem_a[4], wr_snap); end
    run_req(1'b0, 1'b0, 2'b00, 1'b0, 32'h10, 64'h0);
    total++; if (r_resp !== 3 || r_rdata !== 64'h1234_CCDD) begin bad++; $display("FAIL abort_next: got cyc=%0d data=%h want 3/1234ccdd", r_resp, r_rdata); end
  endtask

  initial begin
    reset = 1'b0;
    ifa.req_valid = 1'b0; ifa.req_we = 1'b0; ifa.req_size = 2'b00; ifa.req_signed = 1'b0;
    ifa.req_addr = '0; ifa.req_wdata = '0;
    ifb.req_valid = 1'b0; ifb.req_we = 1'b0; ifb.req_size = 2'b00; ifb.req_signed = 1'b0;
    ifb.req_addr = '0; ifb.req_wdata = '0;
    #12;
    test_reset();
    @(negedge clk);
    reset = 1'b1;
    preload(1'b0, 4'd4, 64'hAABB_CCDD);
    preload(1'b1, 4'd2, 64'h1122_3344_5566_7788);
    test_load_byte();
    test_store_half();
    test_store_word();
    test_misalign();
    test_back_to_back();
    test_wide_load();
    test_reset_abort();
    total++; if (both_hi !== 0) begin bad++; $display("FAIL rd_wr_overlap: got %0d want 0", both_hi); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
